// File: rtl/vram_slot_arbiter.sv
`timescale 1ns/1ps
// Time-slot arbiter for a single synchronous VRAM port shared by the BG fetcher,
// the sprite engine and the CPU. One slot per pixel-clock enable, scheduled from raster state.
module vram_slot_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PCLK_EN,
    input  logic [8:0]        HPOS,
    input  logic              HBLK,
    input  logic              VBLK,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    output logic              bg_ack,
    output logic [DATA_W-1:0] bg_rdata,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_ack,
    output logic [DATA_W-1:0] spr_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] vr_addr,
    output logic              vr_we,
    output logic [DATA_W-1:0] vr_wdata,
    input  logic [DATA_W-1:0] vr_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_BG, OWN_SPR, OWN_CPU} owner_t;

    state_t            state, state_nx;
    owner_t            owner, win;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [CNT_W-1:0]  starve_q;
    logic [DATA_W-1:0] bg_rdata_q, spr_rdata_q, cpu_rdata_q;
    logic              slot_active, slot_hb, slot_vb, bg_slot, starved;
    logic              grant, cpu_lost;
    logic              unused_hpos;

    assign unused_hpos = ^HPOS[8:1];

    assign slot_active = !HBLK && !VBLK;
    assign slot_hb     = HBLK && !VBLK;
    assign slot_vb     = VBLK;
    assign bg_slot     = slot_active && !HPOS[0];
    assign starved     = starve_q >= CNT_W'(STARVE_LIMIT);

    always_comb begin
        win = OWN_NONE;
        if (bg_slot) begin
            if (bg_req) win = OWN_BG;
        end else if (slot_active || slot_vb || (slot_hb && starved)) begin
            if (cpu_req)      win = OWN_CPU;
            else if (spr_req) win = OWN_SPR;
        end else begin
            if (spr_req)      win = OWN_SPR;
            else if (cpu_req) win = OWN_CPU;
        end
    end

    assign grant    = (state == IDLE) && PCLK_EN && (win != OWN_NONE);
    assign cpu_lost = (state == IDLE) && PCLK_EN && cpu_req && !bg_slot && (win == OWN_SPR);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ISSUE;
            ISSUE:   state_nx = DATA;
            DATA:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            starve_q    <= '0;
            bg_rdata_q  <= '0;
            spr_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner   <= win;
                we_q    <= (win == OWN_CPU) && cpu_we;
                wdata_q <= cpu_wdata;
                case (win)
                    OWN_BG:  addr_q <= bg_addr;
                    OWN_SPR: addr_q <= spr_addr;
                    default: addr_q <= cpu_addr;
                endcase
            end else if (state == DATA) begin
                owner <= OWN_NONE;
            end

            if (cpu_ack)
                starve_q <= '0;
            else if (cpu_lost && !starved)
                starve_q <= starve_q + CNT_W'(1);

            if (bg_ack)              bg_rdata_q  <= vr_rdata;
            if (spr_ack)             spr_rdata_q <= vr_rdata;
            if (cpu_ack && !we_q)    cpu_rdata_q <= vr_rdata;
        end
    end

    // Read data is forwarded straight from the RAM during the ack cycle, then held.
    assign bg_ack    = (state == DATA) && (owner == OWN_BG);
    assign spr_ack   = (state == DATA) && (owner == OWN_SPR);
    assign cpu_ack   = (state == DATA) && (owner == OWN_CPU);
    assign bg_rdata  = bg_ack  ? vr_rdata : bg_rdata_q;
    assign spr_rdata = spr_ack ? vr_rdata : spr_rdata_q;
    assign cpu_rdata = (cpu_ack && !we_q) ? vr_rdata : cpu_rdata_q;

    assign vr_addr  = (state == ISSUE) ? addr_q : '0;
    assign vr_we    = (state == ISSUE) && we_q;
    assign vr_wdata = vr_we ? wdata_q : '0;

endmodule
